reaction_ctrl: RTL and testbench
================================

# reaction_ctrl

Round sequencer for the reaction-speed game. Takes the debounced start and react button levels, waits a pseudo-random delay, lights the GO lamp and measures reaction time in milliseconds. It flags false starts and timeouts, and optionally tracks the best time. Sits between the per-button debouncers and the display/LED drivers.

## Interface
- TICK_DIV, 100000: clk cycles per millisecond tick (100 MHz clk).
- MIN_DELAY_MS, 1000: fixed part of the GO delay, in ms.
- RAND_BITS, 11: width of the random delay add-on (0..2^RAND_BITS-1 ms).
- MAX_MS, 9999: reaction timeout, in ms; must be ≤16383.
- Constraint: MIN_DELAY_MS + 2^RAND_BITS - 1 ≤ 16383.

- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- start_btn  in  1  debounced start button level.
- react_btn  in  1  debounced react button level.
- go_led  out  1  high while in GO.
- false_start  out  1  high while in FOUL.
- timeout  out  1  high while in TMO.
- result_valid  out  1  one-cycle pulse on entry to RESULT.
- result_ms  out  14  last reaction time in ms; held until the next RESULT.
- best_ms  out  14  best reaction time; 14'h3FFF means none.
- state  out  3  IDLE=0, DELAY=1, GO=2, RESULT=3, FOUL=4, TMO=5.

## Operation
- **Edge detect**
  - Each button has a previous-value register, reset to 1, so a button held through reset produces no edge.
  - rise = btn & ~prev (combinational).
- **Millisecond timebase**
  - Prescaler counts 0..TICK_DIV-1 and asserts tick on wrap.
  - Prescaler and ms_cnt (14-bit) clear on every state transition, so the first ms after a transition is a full ms.
  - ms_cnt increments on tick and saturates at 16383.
- **Random delay source**
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset.
  - Free-runs every cycle.
  - On a start rise that enters DELAY: delay_tgt = MIN_DELAY_MS + lfsr[RAND_BITS-1:0].
- **FSM transitions**
  - IDLE: start rise → DELAY.
  - DELAY:
    - react rise → FOUL.
    - Otherwise, tick with ms_cnt+1 == delay_tgt → GO.
    - react rise wins over the GO transition in the same cycle.
  - GO:
    - react rise → RESULT; result_ms ← ms_cnt.
    - Otherwise, tick with ms_cnt+1 == MAX_MS → TMO.
    - react rise wins over the timeout in the same cycle.
  - RESULT, FOUL, TMO: start rise → DELAY, which begins a new round with a new delay_tgt.
  - A start rise is ignored in DELAY and GO. A react rise is ignored in IDLE, RESULT, FOUL and TMO.
- **Reset**
  - Reset mid-round returns to IDLE immediately (asynchronous).
  - All outputs are 0, except best_ms = 14'h3FFF.
  - result_ms = 0.

## Timing
- All outputs are registered or decoded from the state register; no combinational path from inputs to outputs.
- React rise in cycle N (GO) → state=RESULT, result_valid=1 and result_ms valid in cycle N+1. result_valid is 0 in cycle N+2.
- GO is entered in the cycle after the tick that matches delay_tgt; go_led is high in that same cycle.
- Measured time = number of complete ms ticks between GO entry and the react edge. Resolution is 1 ms, truncated.
- Delay accuracy: exactly delay_tgt × TICK_DIV cycles from DELAY entry to GO entry.

## Configuration
- **REACTION_CTRL_BEST_EN defined**
  - On entry to RESULT: if the new result_ms < best_ms, then best_ms ← new result_ms, in the same cycle as result_ms.
  - best_ms resets to 14'h3FFF only on rst_n.
- **REACTION_CTRL_BEST_EN undefined**
  - No compare logic or best register.
  - best_ms is tied to 14'h3FFF.

## Test plan
Bench parameters: TICK_DIV=10, MIN_DELAY_MS=5, RAND_BITS=3, MAX_MS=20.
- **Normal round:** reset release, start rise; delay_tgt = 5 + lfsr[2:0] at the edge. React rise 7 ms after GO → result_valid single pulse, result_ms=7, best_ms=7 (BEST_EN).
- **Second round:** a 4 ms result updates best_ms to 4; a following 9 ms result leaves best_ms=4. Without BEST_EN, best_ms stays 14'h3FFF throughout.
- **False start:** react rise 2 ms into DELAY → state=FOUL, false_start=1, go_led never asserted; start rise → DELAY.
- **Timeout:** no react in GO → TMO exactly 20×10 cycles after GO entry, timeout=1, result_ms unchanged.
- **Simultaneous events:** react rise on the cycle of the DELAY target tick → FOUL. React rise on the cycle of the MAX_MS tick → RESULT with result_ms=19.
- **Reset and held buttons:**
  - rst_n low mid-GO → IDLE, all outputs 0, best_ms=14'h3FFF.
  - start_btn held high through reset release → stays IDLE until release and re-press.

Source files
------------

// File: rtl/reaction_ctrl_if.sv
// Button-in / lamp-and-display-out bundle for the reaction game sequencer.
// slave: the sequencer side; master: the debouncer/display side.
interface reaction_ctrl_if;
    logic        start_btn;
    logic        react_btn;
    logic        go_led;
    logic        false_start;
    logic        timeout;
    logic        result_valid;
    logic [13:0] result_ms;
    logic [13:0] best_ms;
    logic [2:0]  state;

    modport master (
        output start_btn, react_btn,
        input  go_led, false_start, timeout, result_valid, result_ms, best_ms, state
    );

    modport slave (
        input  start_btn, react_btn,
        output go_led, false_start, timeout, result_valid, result_ms, best_ms, state
    );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-game round sequencer: random GO delay, ms reaction timing, foul/timeout.
// Optional best-time tracking is enabled by defining REACTION_CTRL_BEST_EN.
module reaction_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 9999
) (
    input logic            clk,
    input logic            rst_n,
    reaction_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DELAY  = 3'd1,
        S_GO     = 3'd2,
        S_RESULT = 3'd3,
        S_FOUL   = 3'd4,
        S_TMO    = 3'd5
    } state_t;

    localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0]     MS_SAT   = 14'h3FFF;
    localparam logic [13:0]     MAX_LAST = 14'(MAX_MS);
    localparam logic [13:0]     MIN_DLY  = 14'(MIN_DELAY_MS);

    state_t        state_q, state_d;
    logic          start_prev, react_prev;
    logic          start_rise, react_rise;
    logic [PW-1:0] pre_q;
    logic [13:0]   ms_q, ms_plus;
    logic          tick;
    logic [15:0]   lfsr_q;
    logic [13:0]   tgt_q;
    logic [13:0]   result_q;
    logic          valid_q;
    logic          load_tgt, capture;

    // Previous levels reset high so a button held through reset gives no edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev <= 1'b1;
            react_prev <= 1'b1;
        end else begin
            start_prev <= bus.start_btn;
            react_prev <= bus.react_btn;
        end
    end

    assign start_rise = bus.start_btn & ~start_prev;
    assign react_rise = bus.react_btn & ~react_prev;
    assign tick       = (pre_q == PRE_LAST);
    assign ms_plus    = ms_q + 14'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        load_tgt = 1'b0;
        capture  = 1'b0;
        case (state_q)
            S_IDLE, S_RESULT, S_FOUL, S_TMO: begin
                if (start_rise) begin
                    state_d  = S_DELAY;
                    load_tgt = 1'b1;
                end
            end
            S_DELAY: begin
                if (react_rise)                     state_d = S_FOUL;
                else if (tick && ms_plus == tgt_q)  state_d = S_GO;
            end
            S_GO: begin
                if (react_rise) begin
                    state_d = S_RESULT;
                    capture = 1'b1;
                end else if (tick && ms_plus == MAX_LAST) begin
                    state_d = S_TMO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timebase restarts on every transition so each phase begins with a full ms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            ms_q  <= '0;
        end else if (state_d != state_q) begin
            pre_q <= '0;
            ms_q  <= '0;
        end else if (tick) begin
            pre_q <= '0;
            if (ms_q != MS_SAT) ms_q <= ms_plus;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
            tgt_q  <= '0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            if (load_tgt) tgt_q <= MIN_DLY + 14'(lfsr_q[RAND_BITS-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= capture;
            if (capture) result_q <= ms_q;
        end
    end

`ifdef REACTION_CTRL_BEST_EN
    logic [13:0] best_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          best_q <= MS_SAT;
        else if (capture && ms_q < best_q)   best_q <= ms_q;
    end

    assign bus.best_ms = best_q;
`else
    assign bus.best_ms = MS_SAT;
`endif

    assign bus.state        = state_q;
    assign bus.go_led       = (state_q == S_GO);
    assign bus.false_start  = (state_q == S_FOUL);
    assign bus.timeout      = (state_q == S_TMO);
    assign bus.result_valid = valid_q;
    assign bus.result_ms    = result_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: cycle-count reference model plus directed and random rounds.
// Best-time expectations follow REACTION_CTRL_BEST_EN.
module tb_reaction_ctrl;

    localparam int TD   = 10;
    localparam int MIN  = 5;
    localparam int RB   = 3;
    localparam int MAXM = 20;
`ifdef REACTION_CTRL_BEST_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    reaction_ctrl_if bus ();

    reaction_ctrl #(
        .TICK_DIV(TD), .MIN_DELAY_MS(MIN), .RAND_BITS(RB), .MAX_MS(MAXM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus elapsed cycles since phase entry; ms = elapsed / TD.
    int          m_phase, m_elapsed, m_tgt, m_result, m_best;
    bit          m_valid, m_ps, m_pr;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic m_reset();
        m_phase = 0; m_elapsed = 0; m_tgt = 0; m_result = 0; m_best = 16383;
        m_valid = 0; m_ps = 1; m_pr = 1; m_lfsr = 16'hACE1;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                bit rs, rr;
                int nxt, ms;
                rs  = bus.start_btn && !m_ps;
                rr  = bus.react_btn && !m_pr;
                ms  = (m_elapsed / TD > 16383) ? 16383 : m_elapsed / TD;
                nxt = m_phase;
                m_valid = 0;
                case (m_phase)
                    1: begin
                        if (rr) nxt = 4;
                        else if (m_elapsed + 1 == m_tgt * TD) nxt = 2;
                    end
                    2: begin
                        if (rr) begin
                            nxt = 3;
                            m_result = ms;
                            m_valid = 1;
                            if (BEST_EN && ms < m_best) m_best = ms;
                        end else if (m_elapsed + 1 == MAXM * TD) begin
                            nxt = 5;
                        end
                    end
                    default: begin
                        if (rs) begin
                            nxt = 1;
                            m_tgt = MIN + int'(m_lfsr) % (1 << RB);
                        end
                    end
                endcase
                m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
                m_phase   = nxt;
                m_ps      = bus.start_btn;
                m_pr      = bus.react_btn;
                m_lfsr    = lfsr_step(m_lfsr);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("outputs",
                  64'({bus.state, bus.go_led, bus.false_start, bus.timeout,
                       bus.result_valid, bus.result_ms, bus.best_ms}),
                  64'({3'(m_phase), m_phase == 2, m_phase == 4, m_phase == 5,
                       m_valid, 14'(m_result), 14'(m_best)}));
        end
    end

    task automatic pulse_start();
        bus.start_btn = 1'b1;
        @(negedge clk);
        bus.start_btn = 1'b0;
    endtask

    task automatic pulse_react();
        bus.react_btn = 1'b1;
        @(negedge clk);
        bus.react_btn = 1'b0;
    endtask

    // Called on the first DELAY cycle; returns on the first GO cycle.
    task automatic wait_go();
        int n = 0;
        while (!bus.go_led && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("go_reached", 64'(bus.go_led), 64'd1);
        check("delay_grid", 64'(n % TD == 0 && n >= MIN * TD && n <= (MIN + 7) * TD), 64'd1);
    endtask

    task automatic play_round(input int ms, input int exp_best);
        pulse_start();
        check("enter_delay", 64'(bus.state), 64'd1);
        wait_go();
        repeat (ms * TD) @(negedge clk);
        pulse_react();
        check("round_state", 64'(bus.state), 64'd3);
        check("round_valid", 64'(bus.result_valid), 64'd1);
        check("round_ms", 64'(bus.result_ms), 64'(ms));
        check("round_best", 64'(bus.best_ms), 64'(BEST_EN ? exp_best : 16383));
        @(negedge clk);
        check("valid_pulse_end", 64'(bus.result_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.start_btn = 1'b0;
        bus.react_btn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 64'(bus.state), 64'd0);
        check("reset_best", 64'(bus.best_ms), 64'h3FFF);
        check("reset_result", 64'(bus.result_ms), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        play_round(7, 7);
        play_round(4, 4);
        play_round(9, 4);

        // False start 2 ms into DELAY, then a fresh round.
        pulse_start();
        repeat (2 * TD) @(negedge clk);
        pulse_react();
        check("foul_state", 64'(bus.state), 64'd4);
        check("foul_flag", 64'(bus.false_start), 64'd1);
        check("foul_no_go", 64'(bus.go_led), 64'd0);
        repeat (5) @(negedge clk);
        pulse_start();
        check("foul_restart", 64'(bus.state), 64'd1);

        // Timeout exactly MAXM ms after GO entry.
        wait_go();
        repeat (MAXM * TD - 1) @(negedge clk);
        check("pre_timeout_state", 64'(bus.state), 64'd2);
        @(negedge clk);
        check("tmo_state", 64'(bus.state), 64'd5);
        check("tmo_flag", 64'(bus.timeout), 64'd1);
        check("tmo_result_kept", 64'(bus.result_ms), 64'd9);

        // React on the DELAY target tick: foul wins.
        pulse_start();
        repeat (m_tgt * TD - 1) @(negedge clk);
        pulse_react();
        check("sim_delay_state", 64'(bus.state), 64'd4);

        // React on the MAX_MS tick: result wins with MAXM-1.
        pulse_start();
        wait_go();
        repeat (MAXM * TD - 1) @(negedge clk);
        pulse_react();
        check("sim_max_state", 64'(bus.state), 64'd3);
        check("sim_max_ms", 64'(bus.result_ms), 64'(MAXM - 1));
        check("sim_max_best", 64'(bus.best_ms), 64'(BEST_EN ? 4 : 16383));

        // Asynchronous reset mid-GO.
        pulse_start();
        wait_go();
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_go_state", 64'(bus.state), 64'd0);
        check("rst_go_led", 64'(bus.go_led), 64'd0);
        check("rst_go_result", 64'(bus.result_ms), 64'd0);
        check("rst_go_best", 64'(bus.best_ms), 64'h3FFF);

        // Start held through reset release: no round until re-press.
        bus.start_btn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("held_start_idle", 64'(bus.state), 64'd0);
        bus.start_btn = 1'b0;
        @(negedge clk);
        pulse_start();
        check("held_start_repress", 64'(bus.state), 64'd1);

        // Random button activity against the model.
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) bus.start_btn = ~bus.start_btn;
            if ($urandom_range(0, 24) == 0) bus.react_btn = ~bus.react_btn;
            if (i == 4000) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
